// File: rtl/strb_down_conv_lane_prio_enc.sv
// strb_down_conv lowest-set-bit priority encoder.
// Picks the next pending lane and flags when it is the only lane left.
module lane_prio_enc #(
    parameter int W = 4
) (
    input  logic [W-1:0] req,
    output logic [W-1:0] onehot,
    output logic         single
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot = req & (~req + W'(1));

    // Exactly one bit set: non-zero and clearing the lowest bit leaves zero.
    assign single = (req != '0) && ((req & (req - W'(1))) == '0);

endmodule

// File: rtl/strb_down_conv.sv
// strb_down_conv: strobe-aware wide-to-narrow stream converter.
// Empty lanes are skipped so sparse words compact into dense beats.
module strb_down_conv #(
    parameter int DIN_WIDTH  = 32,
    parameter int DOUT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cen,
    input  logic [DIN_WIDTH-1:0]    din,
    input  logic [DIN_WIDTH/8-1:0]  din_strb,
    input  logic                    din_last,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic [DOUT_WIDTH-1:0]   dout,
    output logic [DOUT_WIDTH/8-1:0] dout_strb,
    output logic                    dout_last,
    output logic                    dout_valid,
    input  logic                    dout_ready
);

    localparam int RATIO     = DIN_WIDTH / DOUT_WIDTH;
    localparam int LANE_STRB = DOUT_WIDTH / 8;
    localparam int IN_STRB   = DIN_WIDTH / 8;

    // Illegal width combinations stop elaboration.
    if ((DIN_WIDTH % 8) != 0 || (DOUT_WIDTH % 8) != 0 ||
        DIN_WIDTH <= DOUT_WIDTH ||
        (DIN_WIDTH % DOUT_WIDTH) != 0) begin : g_bad_params
        $error("strb_down_conv: illegal DIN_WIDTH/DOUT_WIDTH");
    end

    logic [DIN_WIDTH-1:0]  data_q;
    logic [IN_STRB-1:0]    strb_q;
    logic                  last_q;
    logic [RATIO-1:0]      mask_q;

    logic [RATIO-1:0]      sel_oh;
    logic                  single;
    logic [RATIO-1:0]      load_mask;
    logic [DOUT_WIDTH-1:0] sel_data;
    logic [LANE_STRB-1:0]  sel_strb;
    logic                  in_acc;
    logic                  out_acc;

    lane_prio_enc #(
        .W (RATIO)
    ) u_prio (
        .req    (mask_q),
        .onehot (sel_oh),
        .single (single)
    );

    // Pending mask for an incoming word; an empty last word keeps lane 0.
    always_comb begin
        load_mask = '0;
        for (int k = 0; k < RATIO; k++) begin
            load_mask[k] = |din_strb[k*LANE_STRB +: LANE_STRB];
        end
        if (!(|din_strb) && din_last) begin
            load_mask = RATIO'(1);
        end
    end

    // Route the selected lane's data and strobes to the output.
    always_comb begin
        sel_data = '0;
        sel_strb = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (sel_oh[k]) begin
                sel_data |= data_q[k*DOUT_WIDTH +: DOUT_WIDTH];
                sel_strb |= strb_q[k*LANE_STRB +: LANE_STRB];
            end
        end
    end

    assign dout_valid = |mask_q;
    assign dout       = sel_data;
    assign dout_strb  = sel_strb;
    assign dout_last  = last_q & single;

    assign din_ready  = cen & ((mask_q == '0) | (single & dout_ready));
    assign in_acc     = din_valid & din_ready;
    assign out_acc    = dout_valid & dout_ready & cen;

    // Holding register: a new word replaces a retiring last lane.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_q <= '0;
            strb_q <= '0;
            last_q <= 1'b0;
            mask_q <= '0;
        end else if (in_acc) begin
            data_q <= din;
            strb_q <= din_strb;
            last_q <= din_last;
            mask_q <= load_mask;
        end else if (out_acc) begin
            mask_q <= mask_q & ~sel_oh;
        end
    end

endmodule

// File: tb/tb_strb_down_conv.sv
// Directed bench for strb_down_conv.
// Covers 32->8 and 64->16 configurations.
module tb_strb_down_conv;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cen;
    logic [31:0] din;
    logic [3:0]  din_strb;
    logic        din_last;
    logic        din_valid;
    logic        din_ready;
    logic [7:0]  dout;
    logic        dout_strb;
    logic        dout_last;
    logic        dout_valid;
    logic        dout_ready;

    logic        b_cen;
    logic [63:0] b_din;
    logic [7:0]  b_din_strb;
    logic        b_din_last;
    logic        b_din_valid;
    logic        b_din_ready;
    logic [15:0] b_dout;
    logic [1:0]  b_dout_strb;
    logic        b_dout_last;
    logic        b_dout_valid;
    logic        b_dout_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    strb_down_conv #(
        .DIN_WIDTH  (32),
        .DOUT_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cen        (cen),
        .din        (din),
        .din_strb   (din_strb),
        .din_last   (din_last),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_strb  (dout_strb),
        .dout_last  (dout_last),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    strb_down_conv #(
        .DIN_WIDTH  (64),
        .DOUT_WIDTH (16)
    ) dut_b (
        .clk        (clk),
        .rstn       (rstn),
        .cen        (b_cen),
        .din        (b_din),
        .din_strb   (b_din_strb),
        .din_last   (b_din_last),
        .din_valid  (b_din_valid),
        .din_ready  (b_din_ready),
        .dout       (b_dout),
        .dout_strb  (b_dout_strb),
        .dout_last  (b_dout_last),
        .dout_valid (b_dout_valid),
        .dout_ready (b_dout_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic [7:0] d,
                        input logic s, input logic l);
        chk({tag, "_v"}, 64'(dout_valid), 64'd1);
        chk({tag, "_d"}, 64'(dout), 64'(d));
        chk({tag, "_s"}, 64'(dout_strb), 64'(s));
        chk({tag, "_l"}, 64'(dout_last), 64'(l));
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] s,
                        input logic l);
        din       = d;
        din_strb  = s;
        din_last  = l;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        #1;
    endtask

    initial begin
        rstn         = 1'b0;
        cen          = 1'b1;
        din          = '0;
        din_strb     = '0;
        din_last     = 1'b0;
        din_valid    = 1'b0;
        dout_ready   = 1'b0;
        b_cen        = 1'b1;
        b_din        = '0;
        b_din_strb   = '0;
        b_din_last   = 1'b0;
        b_din_valid  = 1'b0;
        b_dout_ready = 1'b1;
        step();
        step();
        rstn = 1'b1;
        #1;

        chk("rst_valid", 64'(dout_valid), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_strb", 64'(dout_strb), 64'd0);
        chk("rst_last", 64'(dout_last), 64'd0);
        chk("rst_ready", 64'(din_ready), 64'd1);

        // full word
        dout_ready = 1'b1;
        send(32'h44332211, 4'hF, 1'b1);
        beat("full0", 8'h11, 1'b1, 1'b0);
        chk("full0_rdy", 64'(din_ready), 64'd0);
        step(); #1;
        beat("full1", 8'h22, 1'b1, 1'b0);
        step(); #1;
        beat("full2", 8'h33, 1'b1, 1'b0);
        step(); #1;
        beat("full3", 8'h44, 1'b1, 1'b1);
        chk("full3_rdy", 64'(din_ready), 64'd1);
        step(); #1;
        chk("full_idle", 64'(dout_valid), 64'd0);

        // sparse word
        send(32'hDDCCBBAA, 4'b0101, 1'b1);
        beat("sp0", 8'hAA, 1'b1, 1'b0);
        chk("sp0_rdy", 64'(din_ready), 64'd0);
        step(); #1;
        beat("sp1", 8'hCC, 1'b1, 1'b1);
        chk("sp1_rdy", 64'(din_ready), 64'd1);
        step(); #1;
        chk("sp_idle", 64'(dout_valid), 64'd0);

        // all-zero strobes
        send(32'h99887766, 4'h0, 1'b0);
        chk("z0_valid", 64'(dout_valid), 64'd0);
        chk("z0_rdy", 64'(din_ready), 64'd1);
        send(32'h000000A5, 4'h0, 1'b1);
        beat("z1", 8'hA5, 1'b0, 1'b1);
        step(); #1;
        chk("z1_idle", 64'(dout_valid), 64'd0);

        // backpressure 1,0,1,0,1
        send(32'h87654321, 4'hF, 1'b0);
        dout_ready = 1'b1; #1;
        beat("bp0", 8'h21, 1'b1, 1'b0);
        step();
        dout_ready = 1'b0; #1;
        beat("bp1", 8'h43, 1'b1, 1'b0);
        step();
        dout_ready = 1'b1; #1;
        beat("bp2", 8'h43, 1'b1, 1'b0);
        step();
        dout_ready = 1'b0; #1;
        beat("bp3", 8'h65, 1'b1, 1'b0);
        step();
        dout_ready = 1'b1; #1;
        beat("bp4", 8'h65, 1'b1, 1'b0);
        step(); #1;
        beat("bp5", 8'h87, 1'b1, 1'b0);
        step(); #1;
        chk("bp_idle", 64'(dout_valid), 64'd0);

        // two words back to back
        din       = 32'h04030201;
        din_strb  = 4'hF;
        din_last  = 1'b0;
        din_valid = 1'b1;
        step();
        din      = 32'h08070605;
        din_last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("str_v", 64'(dout_valid), 64'd1);
            chk("str_d", 64'(dout), 64'(i + 1));
            chk("str_l", 64'(dout_last), 64'(i == 7));
            if (i == 3) chk("str_rdy", 64'(din_ready), 64'd1);
            step();
            if (i == 3) din_valid = 1'b0;
        end
        #1;
        chk("str_idle", 64'(dout_valid), 64'd0);

        // freeze mid-word
        send(32'h0D0C0B0A, 4'hF, 1'b1);
        beat("fz0", 8'h0A, 1'b1, 1'b0);
        step();
        cen       = 1'b0;
        din       = 32'hFFFFFFFF;
        din_last  = 1'b0;
        din_valid = 1'b1;
        #1;
        beat("fz1", 8'h0B, 1'b1, 1'b0);
        chk("fz_rdy", 64'(din_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            beat("fz_hold", 8'h0B, 1'b1, 1'b0);
        end
        cen       = 1'b1;
        din_valid = 1'b0;
        #1;
        beat("fz2", 8'h0B, 1'b1, 1'b0);
        step(); #1;
        beat("fz3", 8'h0C, 1'b1, 1'b0);
        step(); #1;
        beat("fz4", 8'h0D, 1'b1, 1'b1);
        step(); #1;
        chk("fz_idle", 64'(dout_valid), 64'd0);

        // reset mid-word, with cen low
        send(32'h14131211, 4'hF, 1'b1);
        beat("rs0", 8'h11, 1'b1, 1'b0);
        step(); #1;
        beat("rs1", 8'h12, 1'b1, 1'b0);
        rstn = 1'b0;
        cen  = 1'b0;
        step();
        rstn = 1'b1;
        cen  = 1'b1;
        #1;
        chk("rs_valid", 64'(dout_valid), 64'd0);
        chk("rs_dout", 64'(dout), 64'd0);
        chk("rs_last", 64'(dout_last), 64'd0);
        chk("rs_rdy", 64'(din_ready), 64'd1);
        step(); #1;
        chk("rs_valid2", 64'(dout_valid), 64'd0);

        // 64 -> 16 configuration
        b_din       = 64'h1111BEEF22223333;
        b_din_strb  = 8'b0011_0000;
        b_din_last  = 1'b1;
        b_din_valid = 1'b1;
        step();
        b_din_valid = 1'b0;
        #1;
        chk("w_v", 64'(b_dout_valid), 64'd1);
        chk("w_d", 64'(b_dout), 64'hBEEF);
        chk("w_s", 64'(b_dout_strb), 64'h3);
        chk("w_l", 64'(b_dout_last), 64'd1);
        step(); #1;
        chk("w_idle", 64'(b_dout_valid), 64'd0);

        b_din       = 64'hCAFE000000000000;
        b_din_strb  = 8'b1000_0000;
        b_din_valid = 1'b1;
        step();
        b_din_valid = 1'b0;
        #1;
        chk("w2_d", 64'(b_dout), 64'hCAFE);
        chk("w2_s", 64'(b_dout_strb), 64'h2);
        chk("w2_l", 64'(b_dout_last), 64'd1);
        step(); #1;
        chk("w2_idle", 64'(b_dout_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
